// File: rtl/fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arb: 4-way round-robin burst arbiter feeding one shared FIFO.   |
// | Optional macro FIFO_WR_ARB_STATS_EN adds per-requester ack counters.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_wr_arb #(
  parameter int B    = 8,
  parameter int MAXB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*B-1:0] din,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_wdata,
  output logic [3:0]     ack,
  output logic [1:0]     owner,
  output logic           busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [4*16-1:0] wcnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [3:0] r_bcnt;
  logic [3:0] w_bcnt_nxt;
  logic       w_wr;
  logic [1:0] w_pick;
  logic [1:0] w_cand;
  logic       w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_bcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Search starts just after the last releaser, so it gets lowest priority.
  always_comb begin
    w_pick  = r_last;
    w_cand  = r_last;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_last + 2'(k + 1);
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_wr = (r_state == GRANT) && req[r_owner] && !fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick;
          w_bcnt_nxt  = 4'd0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!req[r_owner]) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else if (w_wr) begin
          w_bcnt_nxt = r_bcnt + 4'd1;
          if (r_bcnt == 4'(MAXB - 1)) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
    endcase
  end

  always_comb begin
    ack          = 4'd0;
    ack[r_owner] = w_wr;
  end

  assign fifo_wr    = w_wr;
  assign fifo_wdata = din[r_owner*B +: B];
  assign owner      = r_owner;
  assign busy       = (r_state == GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wcnt
      logic [15:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= 16'd0;
        end else if (ack[gi]) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign wcnt[gi*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [63:0] wcnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arb #(.B(8), .MAXB(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .ack        (ack),
    .owner      (owner),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wcnt       (wcnt)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive on the falling edge, settle, then the caller checks.
  task automatic step(input logic [3:0] r, input logic f);
    @(negedge clk);
    req       = r;
    fifo_full = f;
    #1;
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_wr"},   64'(fifo_wr), 64'd0);
    chk({tag, "_ack"},  64'(ack), 64'd0);
  endtask

  task automatic exp_grant(input string tag, input logic [1:0] o, input logic w);
    logic [3:0] a;
    logic [7:0] d;
    a = w ? (4'b0001 << o) : 4'b0000;
    d = 8'h11 * (8'(o) + 8'd1);
    chk({tag, "_busy"},  64'(busy), 64'd1);
    chk({tag, "_owner"}, 64'(owner), 64'(o));
    chk({tag, "_wr"},    64'(fifo_wr), 64'(w));
    chk({tag, "_ack"},   64'(ack), 64'(a));
    chk({tag, "_wdata"}, 64'(fifo_wdata), 64'(d));
  endtask

  // Asserts reset on a falling edge (async effect checked at once), then
  // releases it one cycle later with r_after driven as the first IDLE sample.
  task automatic do_reset(input logic [3:0] r_after);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_wr",    64'(fifo_wr), 64'd0);
    chk("rst_ack",   64'(ack), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_wcnt",  wcnt, 64'd0);
`endif
    @(negedge clk);
    rst       = 1'b0;
    req       = r_after;
    fifo_full = 1'b0;
    #1;
  endtask

  initial begin
    int seq [5];
    seq       = '{0, 1, 2, 3, 0};
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    din       = 32'h44332211;

    // Single requester: 4-word burst, one bubble, re-grant to the same one.
    do_reset(4'b0001);
    exp_idle("s1_idle");
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0);
      exp_grant($sformatf("s1_w%0d", i), 2'd0, 1'b1);
    end
    step(4'b0001, 1'b0); exp_idle("s1_bubble");
    step(4'b0001, 1'b0); exp_grant("s1_again", 2'd0, 1'b1);
    step(4'b0000, 1'b0); exp_grant("s1_drop", 2'd0, 1'b0);
    step(4'b0000, 1'b0); exp_idle("s1_rel");

    // All requesting: rotation 0,1,2,3,0 with 4-word bursts.
    do_reset(4'b1111);
    exp_idle("s2_idle0");
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        step(4'b1111, 1'b0);
        exp_idle($sformatf("s2_bub%0d", j));
      end
      for (int w = 0; w < 4; w++) begin
        step(4'b1111, 1'b0);
        exp_grant($sformatf("s2_o%0d_w%0d", j, w), 2'(seq[j]), 1'b1);
      end
    end

    // Owner 1 stalls on a full FIFO for 5 cycles mid-burst.
    step(4'b0010, 1'b0); exp_idle("s3_idle");
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, 1'b0); exp_grant($sformatf("s3_pre%0d", i), 2'd1, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b1); exp_grant($sformatf("s3_full%0d", i), 2'd1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b0010, 1'b0); exp_grant($sformatf("s3_post%0d", i), 2'd1, 1'b1);
    end

    // Owner 2 drops its request after one word; requester 3 follows.
    step(4'b0100, 1'b0); exp_idle("s4_bubble");
    step(4'b0100, 1'b0); exp_grant("s4_o2", 2'd2, 1'b1);
    step(4'b1000, 1'b0); exp_grant("s4_drop", 2'd2, 1'b0);
    step(4'b1000, 1'b0); exp_idle("s4_rel");
    step(4'b1000, 1'b0); exp_grant("s4_o3", 2'd3, 1'b1);
    step(4'b1001, 1'b0); exp_grant("s4_ignore0", 2'd3, 1'b1);
    step(4'b0001, 1'b0); exp_grant("s4_drop3", 2'd3, 1'b0);

    // Reset in the middle of owner 2's burst; requester 0 wins afterwards.
    step(4'b0100, 1'b0); exp_idle("s5_idle");
    step(4'b0100, 1'b0); exp_grant("s5_o2", 2'd2, 1'b1);
    do_reset(4'b0101);
    exp_idle("s5_post_rst");
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 1'b0); exp_grant($sformatf("s5_o0_w%0d", i), 2'd0, 1'b1);
    end
    step(4'b0101, 1'b0); exp_idle("s5_bubble");
    step(4'b0101, 1'b0); exp_grant("s5_o2_next", 2'd2, 1'b1);

`ifdef FIFO_WR_ARB_STATS_EN
    // Ten words from requester 3: 4 + 4 + 2.
    do_reset(4'b1000);
    exp_idle("st_idle");
    for (int i = 0; i < 4; i++) begin step(4'b1000, 1'b0); exp_grant("st_a", 2'd3, 1'b1); end
    step(4'b1000, 1'b0); exp_idle("st_b1");
    for (int i = 0; i < 4; i++) begin step(4'b1000, 1'b0); exp_grant("st_b", 2'd3, 1'b1); end
    step(4'b1000, 1'b0); exp_idle("st_b2");
    for (int i = 0; i < 2; i++) begin step(4'b1000, 1'b0); exp_grant("st_c", 2'd3, 1'b1); end
    step(4'b0000, 1'b0); exp_grant("st_drop", 2'd3, 1'b0);
    chk("st_wcnt", wcnt, 64'h000A_0000_0000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter B, 8, data width of each requester word and of the FIFO write port.
REQ-002 SHALL have parameter MAXB, 4, maximum words per grant (burst limit), legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  4  req[i]=1: requester i has a valid word on its data slice.
REQ-006 SHALL have port din  input  4*B  requester i data at din[i*B +: B].
REQ-007 SHALL have port fifo_full  input  1  full flag from the shared FIFO.
REQ-008 SHALL have port fifo_wr  output  1  write strobe to the shared FIFO.
REQ-009 SHALL have port fifo_wdata  output  B  write data to the shared FIFO.
REQ-010 SHALL have port ack  output  4  one-hot; ack[i]=1 means requester i's word is consumed this cycle.
REQ-011 SHALL have port owner  output  2  index of the currently granted requester.
REQ-012 SHALL have port busy  output  1  1 while in GRANT state.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and GRANT, plus registers owner, last (2 bits) and bcnt (4 bits).
REQ-014 SHALL, in IDLE with req!=0, select the first requester with req set searching round-robin from last+1 mod 4, load owner, clear bcnt and enter GRANT.
REQ-015 SHALL remain in IDLE with outputs idle when req==0.
REQ-016 SHALL, in GRANT, drive fifo_wr = req[owner] & !fifo_full combinationally from registered owner.
REQ-017 SHALL drive fifo_wdata = din slice of owner at all times, and ack[owner]=fifo_wr with all other ack bits 0.
REQ-018 SHALL never assert fifo_wr or any ack bit in IDLE.
REQ-019 SHALL increment bcnt on each GRANT cycle with fifo_wr=1.
REQ-020 SHALL release the grant (last<=owner, go to IDLE) when fifo_wr=1 and bcnt==MAXB-1, or when req[owner]=0.
REQ-021 SHALL hold owner, bcnt and GRANT while req[owner]=1 and fifo_full=1 (stall; no burst credit consumed).
REQ-022 SHALL ignore req changes of non-owners during GRANT; they are served only after release.
REQ-023 SHALL give latency of exactly one cycle from req sampled in IDLE to first possible fifo_wr; each release costs exactly one IDLE bubble cycle.
REQ-024 SHALL wrap the round-robin search 3->0; a requester that just released has lowest priority at the next arbitration.

Reset
REQ-025 SHALL on rst=1 immediately force IDLE, owner=0, last=3, bcnt=0, busy=0, fifo_wr=0, ack=0 (and clear statistics counters if compiled in).
REQ-026 SHALL drop any in-progress burst on reset mid-operation, with no partial-word write after rst asserts; requester 0 wins the first arbitration after reset.

Configuration
REQ-027 SHALL, when macro FIFO_WR_ARB_STATS_EN is defined, add output port wcnt (4*16) where wcnt[i*16 +: 16] counts ack[i] pulses, wrapping 0xFFFF->0, cleared only by rst.
REQ-028 SHALL, when FIFO_WR_ARB_STATS_EN is undefined, have no wcnt port and no counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, req=4'b0001, fifo_full=0, MAXB=4 -> fifo_wr high cycles 2..5, ack[0] 4 pulses, IDLE bubble, new burst for requester 0.
REQ-030 SHALL cover: req=4'b1111 held -> owners in order 0,1,2,3,0, each 4 words, fifo_wdata matching owner slice.
REQ-031 SHALL cover: owner 1 mid-burst after 2 words, fifo_full=1 for 5 cycles -> fifo_wr=0, ack=0, owner=1 held, then 2 more words, then release.
REQ-032 SHALL cover: owner 2 drops req after 1 word, req[3]=1 -> release to IDLE, next owner 3 with 1 cycle bubble.
REQ-033 SHALL cover: rst asserted mid-burst of owner 2 -> fifo_wr=0 same cycle; after deassert with req=4'b0101 -> owner 0 first.
REQ-034 SHALL cover, with FIFO_WR_ARB_STATS_EN: 10 words from requester 3 -> wcnt slice 3 = 10, others 0; without macro, build has no wcnt port.
